// File: rtl/dmem_ctrl_if.sv
// Data-memory controller bus: MEM-stage request/response plus the RAM-side port.
// Ports: req_* / stall / rd_* toward the pipeline, ram_* toward the single-port RAM.
// Optional misalign flag is present only when DMEM_MISALIGN_TRAP_EN is defined.

`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`endif
`ifndef MASK_B
`define MASK_B 2'd0
`endif
`ifndef MASK_H
`define MASK_H 2'd1
`endif
`ifndef MASK_W
`define MASK_W 2'd2
`endif

interface dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 12
);
    logic                   req_valid;
    logic                   req_we;
    logic                   req_re;
    logic [`MASK_WIDTH-1:0] req_mask;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   stall;
    logic                   rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   ram_en;
    logic                   ram_we;
    logic [RAM_AW-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic [DATA_W-1:0]      ram_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic                   misalign;
`endif

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_re, req_mask, req_addr, req_wdata, ram_rdata,
        output stall, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata
`ifdef DMEM_MISALIGN_TRAP_EN
        , output misalign
`endif
    );

    // Pipeline + RAM side.
    modport master (
        output req_valid, req_we, req_re, req_mask, req_addr, req_wdata, ram_rdata,
        input  stall, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata
`ifdef DMEM_MISALIGN_TRAP_EN
        , input misalign
`endif
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: loads, word stores, and byte/half stores done as read-merge-write
// on a byte-enable-less RAM with 1-cycle read latency. Loads take 2 cycles (1 stall),
// word stores 1 cycle (no stall), sub-word stores 2 cycles (1 stall).
// Ports: clk, rst (sync, active-high), bus (dmem_ctrl_if.slave).
// Optional macro DMEM_MISALIGN_TRAP_EN: flag and drop misaligned half/word requests
// instead of silently aligning them.

module dmem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 12
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        ST_MERGE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [RAM_AW+1:0]      addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic [`MASK_WIDTH-1:0] mask_q, mask_d;

    logic [RAM_AW+1:0]      req_addr_al;
    logic                   req_misaligned;
    logic [DATA_W-1:0]      lane_mask;
    logic [DATA_W-1:0]      lane_data;
    logic [DATA_W-1:0]      merged;

    // Address bits above the RAM depth are ignored; the address wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[ADDR_W-1:RAM_AW+2];

    // Halves and words are forced onto their natural boundary.
    always_comb begin
        req_addr_al = bus.req_addr[RAM_AW+1:0];
        if (bus.req_mask == `MASK_H) begin
            req_addr_al[0] = 1'b0;
        end else if (bus.req_mask == `MASK_W) begin
            req_addr_al[1:0] = 2'b00;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_misaligned = ((bus.req_mask == `MASK_H) && bus.req_addr[0]) ||
                            ((bus.req_mask == `MASK_W) && (bus.req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // Replace only the target lane of the word just read back.
    always_comb begin
        if (mask_q == `MASK_H) begin
            lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << {addr_q[1], 4'b0000};
            lane_data = {{(DATA_W-16){1'b0}}, data_q} << {addr_q[1], 4'b0000};
        end else begin
            lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {addr_q[1:0], 3'b000};
            lane_data = {{(DATA_W-8){1'b0}}, data_q[7:0]} << {addr_q[1:0], 3'b000};
        end
        merged = (bus.ram_rdata & ~lane_mask) | lane_data;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
        bus.stall     = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_data   = '0;
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
        bus.misalign  = 1'b0;
`endif
        // Outputs are held quiet during reset so an aborted merge never writes.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && (bus.req_we || bus.req_re)) begin
                        if (req_misaligned) begin
`ifdef DMEM_MISALIGN_TRAP_EN
                            bus.misalign = 1'b1;
`endif
                        end else if (bus.req_we) begin
                            bus.ram_en   = 1'b1;
                            bus.ram_addr = req_addr_al[RAM_AW+1:2];
                            if (bus.req_mask == `MASK_W) begin
                                bus.ram_we    = 1'b1;
                                bus.ram_wdata = bus.req_wdata;
                            end else begin
                                bus.stall = 1'b1;
                                addr_d    = req_addr_al;
                                data_d    = bus.req_wdata[15:0];
                                mask_d    = bus.req_mask;
                                state_d   = ST_MERGE;
                            end
                        end else begin
                            bus.ram_en   = 1'b1;
                            bus.ram_addr = req_addr_al[RAM_AW+1:2];
                            bus.stall    = 1'b1;
                            addr_d       = req_addr_al;
                            mask_d       = bus.req_mask;
                            state_d      = LD_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = bus.ram_rdata >> {addr_q[1:0], 3'b000};
                    state_d      = IDLE;
                end
                ST_MERGE: begin
                    bus.ram_en    = 1'b1;
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = addr_q[RAM_AW+1:2];
                    bus.ram_wdata = merged;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl with a behavioural single-port RAM.
// Expected RAM writes and load results are queued by each scenario and
// checked by a monitor when the controller produces them.

`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`endif
`ifndef MASK_B
`define MASK_B 2'd0
`endif
`ifndef MASK_H
`define MASK_H 2'd1
`endif
`ifndef MASK_W
`define MASK_W 2'd2
`endif

module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32), .RAM_AW(12)) bus ();

    dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .RAM_AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM IP model: synchronous, 1-cycle read latency, no byte enables.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [31:0] rq_data [$];

    // Monitor: every RAM write and every rd_valid must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (bus.ram_en && bus.ram_we) begin
                n_checks++;
                if (wq_addr.size() == 0) begin
                    $display("FAIL ram_write_unexpected: got addr=%0h data=%08h, required no write",
                             bus.ram_addr, bus.ram_wdata);
                end else begin
                    logic [11:0] ea;
                    logic [31:0] ed;
                    ea = wq_addr.pop_front();
                    ed = wq_data.pop_front();
                    if (bus.ram_addr !== ea || bus.ram_wdata !== ed)
                        $display("FAIL ram_write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                                 bus.ram_addr, bus.ram_wdata, ea, ed);
                    else n_pass++;
                end
            end
            if (bus.rd_valid) begin
                n_checks++;
                if (rq_data.size() == 0) begin
                    $display("FAIL rd_valid_unexpected: got rd_data=%08h, required no rd_valid", bus.rd_data);
                end else begin
                    logic [31:0] er;
                    er = rq_data.pop_front();
                    if (bus.rd_data !== er)
                        $display("FAIL rd_data: got %08h, required %08h", bus.rd_data, er);
                    else n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_re    = 1'b0;
    endtask

    // Present a request and hold it while stall is high; returns stall cycles seen.
    task automatic do_req(input logic we, input logic re, input logic [1:0] mask,
                          input logic [31:0] addr, input logic [31:0] wdata, output int stalls);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_re    = re;
        bus.req_mask  = mask;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!bus.stall) break;
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 8) begin
            n_checks++;
            $display("FAIL stall_timeout: got %0d stall cycles, required fewer than 8", stalls);
        end
    endtask

    task automatic check_stalls(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) $display("FAIL %s: got %0d stall cycles, required %0d", name, got, req);
        else n_pass++;
    endtask

    task automatic test_reset();
        int errs;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_re    = 1'b1;
        bus.req_mask  = `MASK_W;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        #2;
        errs = 0;
        if (bus.stall !== 1'b0)     errs++;
        if (bus.rd_valid !== 1'b0)  errs++;
        if (bus.rd_data !== 32'h0)  errs++;
        if (bus.ram_en !== 1'b0)    errs++;
        if (bus.ram_we !== 1'b0)    errs++;
        if (bus.ram_addr !== 12'h0) errs++;
        if (bus.ram_wdata !== 32'h0) errs++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (bus.misalign !== 1'b0)  errs++;
`endif
        n_checks++;
        if (errs != 0)
            $display("FAIL reset_outputs: got en=%b we=%b stall=%b rd_valid=%b, required all outputs 0",
                     bus.ram_en, bus.ram_we, bus.stall, bus.rd_valid);
        else n_pass++;
        bus.req_valid = 1'b0;
        bus.req_re    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word();
        int s;
        wq_addr.push_back(12'd4); wq_data.push_back(32'hDEADBEEF);
        do_req(1'b1, 1'b0, `MASK_W, 32'h10, 32'hDEADBEEF, s);
        check_stalls("sw_stalls", s, 0);
        rq_data.push_back(32'hDEADBEEF);
        do_req(1'b0, 1'b1, `MASK_W, 32'h10, 32'h0, s);
        check_stalls("lw_stalls", s, 1);
        // Upper address bits wrap modulo the RAM depth.
        rq_data.push_back(32'hDEADBEEF);
        do_req(1'b0, 1'b1, `MASK_W, 32'h0000_4010, 32'h0, s);
        idle();
    endtask

    task automatic test_byte_merge();
        int s;
        wq_addr.push_back(12'd8); wq_data.push_back(32'h11223344);
        do_req(1'b1, 1'b0, `MASK_W, 32'h20, 32'h11223344, s);
        wq_addr.push_back(12'd8); wq_data.push_back(32'h11AA3344);
        do_req(1'b1, 1'b0, `MASK_B, 32'h22, 32'hFFFF_FFAA, s);
        check_stalls("sb_stalls", s, 1);
        rq_data.push_back(32'h000011AA);
        do_req(1'b0, 1'b1, `MASK_B, 32'h22, 32'h0, s);
        idle();
    endtask

    task automatic test_half_merge();
        int s;
        wq_addr.push_back(12'd12); wq_data.push_back(32'h55667788);
        do_req(1'b1, 1'b0, `MASK_W, 32'h30, 32'h55667788, s);
        wq_addr.push_back(12'd12); wq_data.push_back(32'hBEEF7788);
        do_req(1'b1, 1'b0, `MASK_H, 32'h32, 32'h0000BEEF, s);
        check_stalls("sh_stalls", s, 1);
        wq_addr.push_back(12'd12); wq_data.push_back(32'hBEEF1234);
        do_req(1'b1, 1'b0, `MASK_H, 32'h30, 32'hAAAA1234, s);
        rq_data.push_back(32'hBEEF1234);
        do_req(1'b0, 1'b1, `MASK_W, 32'h30, 32'h0, s);
        idle();
    endtask

    task automatic test_reset_mid_store();
        int s;
        int errs;
        wq_addr.push_back(12'd8); wq_data.push_back(32'h11223344);
        do_req(1'b1, 1'b0, `MASK_W, 32'h20, 32'h11223344, s);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_re    = 1'b0;
        bus.req_mask  = `MASK_B;
        bus.req_addr  = 32'h22;
        bus.req_wdata = 32'h000000AA;
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) $display("FAIL rst_sb_stall: got %b, required 1", bus.stall);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.ram_we !== 1'b0) $display("FAIL rst_merge_we: got %b, required 0", bus.ram_we);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        #2;
        errs = 0;
        if (bus.stall !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) errs++;
        if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) errs++;
        if (bus.ram_addr !== 12'h0 || bus.ram_wdata !== 32'h0) errs++;
        n_checks++;
        if (errs != 0)
            $display("FAIL rst_after_outputs: got en=%b we=%b stall=%b rd_valid=%b, required all 0",
                     bus.ram_en, bus.ram_we, bus.stall, bus.rd_valid);
        else n_pass++;
        rq_data.push_back(32'h11223344);
        do_req(1'b0, 1'b1, `MASK_W, 32'h20, 32'h0, s);
        idle();
    endtask

    task automatic test_back_to_back();
        int s;
        rq_data.push_back(32'hDEADBEEF);
        do_req(1'b0, 1'b1, `MASK_W, 32'h10, 32'h0, s);
        check_stalls("b2b_lw0_stalls", s, 1);
        rq_data.push_back(32'hBEEF1234);
        do_req(1'b0, 1'b1, `MASK_W, 32'h30, 32'h0, s);
        check_stalls("b2b_lw1_stalls", s, 1);
        // Both enables set: the store takes precedence.
        wq_addr.push_back(12'd16); wq_data.push_back(32'hCAFEF00D);
        do_req(1'b1, 1'b1, `MASK_W, 32'h40, 32'hCAFEF00D, s);
        check_stalls("b2b_sw_stalls", s, 0);
        rq_data.push_back(32'h00CAFEF0);
        do_req(1'b0, 1'b1, `MASK_B, 32'h41, 32'h0, s);
        check_stalls("b2b_lb_stalls", s, 1);
        idle();
    endtask

    task automatic test_misalign();
        int s;
`ifdef DMEM_MISALIGN_TRAP_EN
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_re    = 1'b1;
        bus.req_mask  = `MASK_W;
        bus.req_addr  = 32'h13;
        #1;
        n_checks++;
        if (bus.misalign !== 1'b1 || bus.ram_en !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL misalign_lw: got misalign=%b en=%b stall=%b, required 1 0 0",
                     bus.misalign, bus.ram_en, bus.stall);
        else n_pass++;
        idle();
        #1;
        n_checks++;
        if (bus.misalign !== 1'b0) $display("FAIL misalign_clear: got %b, required 0", bus.misalign);
        else n_pass++;
`else
        rq_data.push_back(32'hDEADBEEF);
        do_req(1'b0, 1'b1, `MASK_W, 32'h13, 32'h0, s);
        check_stalls("unaligned_lw_stalls", s, 1);
        rq_data.push_back(32'h0000BEEF);
        do_req(1'b0, 1'b1, `MASK_H, 32'h33, 32'h0, s);
        idle();
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_re    = 1'b0;
        bus.req_mask  = `MASK_W;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.ram_rdata = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

        test_reset();
        test_word();
        test_byte_merge();
        test_half_merge();
        test_reset_mid_store();
        test_back_to_back();
        test_misalign();

        repeat (4) @(negedge clk);
        n_checks++;
        if (rq_data.size() != 0 || wq_addr.size() != 0)
            $display("FAIL drain: got %0d loads and %0d writes outstanding, required 0 and 0",
                     rq_data.size(), wq_addr.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
